// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: access size codes,
// FSM state encoding and the alignment rule.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Size code 11 behaves as a word, so any size with bit 1 set needs word alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// Byte/half lane handling: extracts and extends load data from a memory word,
// and merges sub-word store data into a previously read word.
module dm_lane_mux
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  off,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic signed [7:0]  b_lane;
    logic signed [15:0] h_lane;
    logic signed [31:0] b_ext;
    logic signed [31:0] h_ext;

    always_comb begin
        b_lane  = word[8*off +: 8];
        h_lane  = word[16*off[1] +: 16];
        b_ext   = b_lane;
        h_ext   = h_lane;
        ld_data = word;
        st_word = word;
        case (size)
            SZ_B: begin
                ld_data = sext ? b_ext : {24'd0, b_lane};
                st_word[8*off +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ld_data = sext ? h_ext : {16'd0, h_lane};
                st_word[16*off[1] +: 16] = wdata;
            end
            default: begin
                ld_data = word;
                st_word = word;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit between the core and a word-wide data memory. Sub-word
// stores are done as read-modify-write; misaligned accesses complete with err.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic          dm_wr,
    input  logic [31:0]   dm_dout
);

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic        misalign;
    logic        subword;
    logic        we_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        addr_unused;

    // Address bits above the memory are deliberately dropped so accesses wrap.
    assign addr_unused = ^addr[31:AW+2];
    assign accept      = (state == ST_IDLE) && req;
    assign misalign    = is_misaligned(size, addr[1:0]);
    assign subword     = (size == SZ_B) || (size == SZ_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misalign)           state_nx = ST_DONE;
                    else if (we && !subword) state_nx = ST_WR;
                    else                    state_nx = ST_RD;
                end
            end
            ST_RD:   state_nx = we_q ? ST_WR : ST_DONE;
            ST_WR:   state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            sext_q  <= sext;
            size_q  <= size;
            off_q   <= addr[1:0];
            wdata_q <= wdata[15:0];
        end
    end

    dm_lane_mux u_lane (
        .word    (dm_dout),
        .wdata   (wdata_q),
        .size    (size_q),
        .sext    (sext_q),
        .off     (off_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    // dm_wr follows the next state so it is high for the WR cycle only and
    // drops asynchronously with reset, before memory sees the negedge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_wr   <= 1'b0;
            dm_addr <= '0;
            dm_din  <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            dm_wr <= (state_nx == ST_WR);
            if (accept) begin
                dm_addr <= addr[AW+1:2];
                dm_din  <= wdata;
                err     <= misalign;
            end
            if (state == ST_RD) begin
                if (we_q) dm_din <= st_word;
                else      rdata  <= ld_data;
            end
        end
    end

endmodule

// File: doc/dm_lsu.md
DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width toward data memory (10 = 4 KB).
REQ-002 SHALL have port clk  in  1  core clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  in  1  access request from core; sampled only in IDLE.
REQ-005 SHALL have port we  in  1  1 = store, 0 = load.
REQ-006 SHALL have port size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 SHALL have port sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 SHALL have port addr  in  32  byte address.
REQ-009 SHALL have port wdata  in  32  store data, right-justified.
REQ-010 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port err  out  1  misalignment flag, valid with done.
REQ-013 SHALL have port rdata  out  32  load result, valid with done and held until next done.
REQ-014 SHALL have port dm_addr  out  AW  word address to memory.
REQ-015 SHALL have port dm_din  out  32  write word to memory.
REQ-016 SHALL have port dm_wr  out  1  memory write enable.
REQ-017 SHALL have port dm_dout  in  32  memory read word; memory updates it on negedge clk when dm_wr=0.

Function
REQ-018 SHALL have states IDLE, RD, WR, DONE; memory outputs registered, updated on posedge only.
REQ-019 SHALL accept a request in IDLE at the posedge where req=1; it SHALL latch addr, we, size, sext, wdata at that edge.
REQ-020 SHALL drive dm_addr = addr[AW+1:2]; upper address bits SHALL be ignored (wrap within memory).
REQ-021 SHALL flag misalignment for half with addr[0]=1 or word with addr[1:0]!=0: IDLE->DONE, err=1, no dm_wr, rdata unchanged.
REQ-022 SHALL use load path IDLE->RD->DONE: dm_wr=0 in RD; dm_dout captured at the posedge leaving RD.
REQ-023 SHALL use word-store path IDLE->WR->DONE with dm_din=wdata, dm_wr=1 in WR only.
REQ-024 SHALL use sub-word store path IDLE->RD->WR->DONE: read-modify-write, merging wdata lanes into captured dm_dout, other bytes unchanged.
REQ-025 SHALL use little-endian lanes: byte n occupies bits [8n+7:8n], n=addr[1:0]; half at addr[1]=h occupies bits [16h+15:16h].
REQ-026 SHALL right-justify load results and extend them per sext; word loads ignore sext.
REQ-027 SHALL assert done and busy for exactly the DONE cycle, then return to IDLE; req in DONE SHALL be ignored.
REQ-028 SHALL keep latency from accept edge to done: load 2 cycles, word store 2, sub-word store 3, misaligned 1.
REQ-029 SHALL assert dm_wr only in WR; never in two consecutive cycles.

Reset
REQ-030 SHALL on rst_n=0 immediately force state=IDLE, busy=0, done=0, err=0, rdata=0, dm_wr=0, dm_addr=0, dm_din=0.
REQ-031 SHALL abort any in-flight access on reset; reset asserted in WR before the negedge SHALL prevent the memory write.

Structure
REQ-032 SHALL place size codes (SZ_B, SZ_H, SZ_W) and state encoding in shared package dm_pkg.
REQ-033 SHALL put lane extract/extend and lane merge logic in one combinational sub-module, dm_lane_mux.

Verification
REQ-034 SHALL verify word store then load: store 0x8899AABB to 0x004 -> dm_wr one cycle, done 2 cycles after accept; load 0x004 -> rdata 0x8899AABB.
REQ-035 SHALL verify signed/unsigned byte loads: with word 0x8899AABB at 0x004, lb 0x007 -> 0xFFFFFF88; lbu 0x006 -> 0x00000099.
REQ-036 SHALL verify sub-word store: sh 0x1234 to 0x006 -> word 0x004 becomes 0x1234AABB, done 3 cycles after accept, dm_wr high exactly one cycle.
REQ-037 SHALL verify misalignment: lw 0x005 -> done next cycle with err=1, dm_wr never high, rdata unchanged.
REQ-038 SHALL verify reset mid-store: rst_n low during WR of sw 0xDEADBEEF to 0x010 -> memory word unchanged, all outputs reset values.
REQ-039 SHALL verify address wrap: lw 0x1004 -> reads word 0x004; req held high through DONE -> second access accepted only after return to IDLE.
